// File: rtl/handshake_rtl_monitor.sv
// Passive protocol checker for a bank of valid/ready channels.
// It counts completed transfers and raises sticky flags for valid drops, payload changes while stalled, and stall timeouts.
module handshake_rtl_monitor #(
    parameter int NUM_CHANNELS = 3,
    parameter int DATA_WIDTH   = 5,
    parameter int TIMEOUT      = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               CLK,
    input  logic                               RESETN,
    input  logic                               enable,
    input  logic                               clear,
    input  logic [NUM_CHANNELS-1:0]            ch_valid,
    input  logic [NUM_CHANNELS-1:0]            ch_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0]  xfer_count,
    output logic [NUM_CHANNELS-1:0]            err_valid_drop,
    output logic [NUM_CHANNELS-1:0]            err_data_change,
    output logic [NUM_CHANNELS-1:0]            err_timeout,
    output logic                               any_error
);

    // Handshake rule being checked: a transfer happens on an enabled rising edge with valid & ready.
    // Once valid is raised without ready, valid must stay high and the payload must stay stable until ready arrives.

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_W = WCW'(TIMEOUT);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        // The per-channel state_q is the debug view of each FSM: IDLE or WAIT.
        state_t                state_q, state_d;
        logic [DATA_WIDTH-1:0] hold_q, hold_d;
        logic [WCW-1:0]        wcnt_q, wcnt_d;
        logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
        logic                  drop_q, drop_d;
        logic                  chg_q, chg_d;
        logic                  tmo_q, tmo_d;
        logic                  valid;
        logic                  ready;
        logic [DATA_WIDTH-1:0] data;

        assign valid = ch_valid[i];
        assign ready = ch_ready[i];
        assign data  = ch_data[i*DATA_WIDTH +: DATA_WIDTH];

        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            wcnt_d  = wcnt_q;
            cnt_d   = cnt_q;
            drop_d  = drop_q;
            chg_d   = chg_q;
            tmo_d   = tmo_q;

            if (!enable) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                if (valid && ready) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end else if (valid) begin
                    state_d = ST_WAIT;
                    hold_d  = data;
                    wcnt_d  = WCW'(1);
                end
            end else begin
                if (!valid) begin
                    drop_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // The completing edge is still held to the captured payload.
                    if (data != hold_q) chg_d = 1'b1;
                    if (ready) begin
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        state_d = ST_IDLE;
                    end else if (wcnt_q < TIMEOUT_W) begin
                        wcnt_d = wcnt_q + 1'b1;
                        if (wcnt_q == TIMEOUT_W - 1'b1) tmo_d = 1'b1;
                    end
                end
            end

            // Clear drops same-edge events but leaves the stall tracking running.
            if (clear) begin
                cnt_d  = '0;
                drop_d = 1'b0;
                chg_d  = 1'b0;
                tmo_d  = 1'b0;
            end
        end

        always_ff @(posedge CLK) begin
            if (!RESETN) begin
                state_q <= ST_IDLE;
                hold_q  <= '0;
                wcnt_q  <= '0;
                cnt_q   <= '0;
                drop_q  <= 1'b0;
                chg_q   <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
                wcnt_q  <= wcnt_d;
                cnt_q   <= cnt_d;
                drop_q  <= drop_d;
                chg_q   <= chg_d;
                tmo_q   <= tmo_d;
            end
        end

        assign xfer_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        assign err_valid_drop[i]                    = drop_q;
        assign err_data_change[i]                   = chg_q;
        assign err_timeout[i]                       = tmo_q;
    end

    // Summary flag lags the per-channel flags by one register stage.
    always_ff @(posedge CLK) begin
        if (!RESETN || clear) begin
            any_error <= 1'b0;
        end else begin
            any_error <= |{err_valid_drop, err_data_change, err_timeout};
        end
    end

endmodule

// File: tb/tb_handshake_rtl_monitor.sv
// Bench for handshake_rtl_monitor: a default instance and a small one (TIMEOUT=4, CNT_WIDTH=3) share all stimulus.
// Both instances are checked against a transaction-level model, plus directed expectations.
module tb_handshake_rtl_monitor;
    localparam int NC = 3;
    localparam int DW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn, en, clr;
    logic [NC-1:0]    v, r;
    logic [NC*DW-1:0] d;

    logic [NC*16-1:0] xc_m;
    logic [NC*3-1:0]  xc_s;
    logic [NC-1:0]    drop_m, chg_m, tmo_m, drop_s, chg_s, tmo_s;
    logic             any_m, any_s;

    handshake_rtl_monitor #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .TIMEOUT(16), .CNT_WIDTH(16)) dut (
        .CLK(clk), .RESETN(rstn), .enable(en), .clear(clr),
        .ch_valid(v), .ch_ready(r), .ch_data(d),
        .xfer_count(xc_m), .err_valid_drop(drop_m), .err_data_change(chg_m),
        .err_timeout(tmo_m), .any_error(any_m)
    );

    handshake_rtl_monitor #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .TIMEOUT(4), .CNT_WIDTH(3)) dut_s (
        .CLK(clk), .RESETN(rstn), .enable(en), .clear(clr),
        .ch_valid(v), .ch_ready(r), .ch_data(d),
        .xfer_count(xc_s), .err_valid_drop(drop_s), .err_data_change(chg_s),
        .err_timeout(tmo_s), .any_error(any_s)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each stall is tracked as an open transaction with its captured payload and age.
    int              m_cnt  [2][NC];
    bit              m_drop [2][NC];
    bit              m_chg  [2][NC];
    bit              m_tmo  [2][NC];
    bit              m_any  [2];
    bit              m_open [2][NC];
    logic [DW-1:0]   m_cap  [2][NC];
    int              m_age  [2][NC];
    int              lim_tmo[2] = '{16, 4};
    int              lim_cnt[2] = '{65535, 7};

    typedef struct {
        logic        rs, e, cl;
        logic [2:0]  vv, rr;
        logic [14:0] dd;
        logic [15:0] c0, c1;
        logic [2:0]  dr, ch, tm;
        logic        an;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic rs, input logic e, input logic cl,
                                input logic [2:0] vv, input logic [2:0] rr, input logic [14:0] dd,
                                input logic [15:0] c0, input logic [15:0] c1,
                                input logic [2:0] dr, input logic [2:0] ch, input logic [2:0] tm,
                                input logic an);
        vec_t t;
        t.rs = rs; t.e = e; t.cl = cl; t.vv = vv; t.rr = rr; t.dd = dd;
        t.c0 = c0; t.c1 = c1; t.dr = dr; t.ch = ch; t.tm = tm; t.an = an;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit any_n;
            any_n = 1'b0;
            for (int c = 0; c < NC; c++) any_n |= m_drop[k][c] | m_chg[k][c] | m_tmo[k][c];
            for (int c = 0; c < NC; c++) begin
                bit ev_x, ev_d, ev_c, ev_t;
                logic [DW-1:0] dc;
                ev_x = 1'b0; ev_d = 1'b0; ev_c = 1'b0; ev_t = 1'b0;
                dc = d[c*DW +: DW];
                if (!rstn) begin
                    m_open[k][c] = 1'b0; m_age[k][c] = 0; m_cap[k][c] = '0;
                    m_cnt[k][c] = 0; m_drop[k][c] = 1'b0; m_chg[k][c] = 1'b0; m_tmo[k][c] = 1'b0;
                end else begin
                    if (!en) begin
                        m_open[k][c] = 1'b0;
                    end else if (m_open[k][c]) begin
                        if (!v[c]) begin
                            ev_d = 1'b1;
                            m_open[k][c] = 1'b0;
                        end else begin
                            if (dc != m_cap[k][c]) ev_c = 1'b1;
                            if (r[c]) begin
                                ev_x = 1'b1;
                                m_open[k][c] = 1'b0;
                            end else begin
                                m_age[k][c]++;
                                if (m_age[k][c] == lim_tmo[k]) ev_t = 1'b1;
                            end
                        end
                    end else if (v[c] && r[c]) begin
                        ev_x = 1'b1;
                    end else if (v[c]) begin
                        m_open[k][c] = 1'b1;
                        m_cap[k][c]  = dc;
                        m_age[k][c]  = 1;
                    end
                    if (clr) begin
                        m_cnt[k][c] = 0; m_drop[k][c] = 1'b0; m_chg[k][c] = 1'b0; m_tmo[k][c] = 1'b0;
                    end else begin
                        if (ev_x && m_cnt[k][c] < lim_cnt[k]) m_cnt[k][c]++;
                        m_drop[k][c] |= ev_d;
                        m_chg[k][c]  |= ev_c;
                        m_tmo[k][c]  |= ev_t;
                    end
                end
            end
            m_any[k] = rstn && !clr && any_n;
        end
    endtask

    task automatic check_model(input string tag);
        logic [NC-1:0] ed0, ec0, et0, ed1, ec1, et1;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s cnt_main ch%0d", tag, c), 32'(xc_m[c*16 +: 16]), 32'(m_cnt[0][c]));
            chk($sformatf("%s cnt_small ch%0d", tag, c), 32'(xc_s[c*3 +: 3]), 32'(m_cnt[1][c]));
            ed0[c] = m_drop[0][c]; ec0[c] = m_chg[0][c]; et0[c] = m_tmo[0][c];
            ed1[c] = m_drop[1][c]; ec1[c] = m_chg[1][c]; et1[c] = m_tmo[1][c];
        end
        chk({tag, " drop_main"}, 32'(drop_m), 32'(ed0));
        chk({tag, " chg_main"},  32'(chg_m),  32'(ec0));
        chk({tag, " tmo_main"},  32'(tmo_m),  32'(et0));
        chk({tag, " any_main"},  32'(any_m),  32'(m_any[0]));
        chk({tag, " drop_small"}, 32'(drop_s), 32'(ed1));
        chk({tag, " chg_small"},  32'(chg_s),  32'(ec1));
        chk({tag, " tmo_small"},  32'(tmo_s),  32'(et1));
        chk({tag, " any_small"},  32'(any_s),  32'(m_any[1]));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic step(input string tag, input logic rs, input logic e, input logic cl,
                        input logic [2:0] vv, input logic [2:0] rr, input logic [14:0] dd);
        rstn = rs; en = e; clr = cl; v = vv; r = rr; d = dd;
        tick(tag);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; clr = 1'b0; v = '0; r = '0; d = '0;

        // rs e cl  v  r  data  c0 c1 drop chg tmo any
        tbl[0]  = mk(0, 0, 0, 3'b000, 3'b000, 15'h000, 16'd0, 16'd0, 3'b000, 3'b000, 3'b000, 0);
        for (int i = 1; i <= 5; i++)
            tbl[i] = mk(1, 1, 0, 3'b001, 3'b001, 15'h000, 16'(i), 16'd0, 3'b000, 3'b000, 3'b000, 0);
        tbl[6]  = mk(1, 1, 0, 3'b000, 3'b000, 15'h000, 16'd5, 16'd0, 3'b000, 3'b000, 3'b000, 0);
        for (int i = 7; i <= 9; i++)
            tbl[i] = mk(1, 1, 0, 3'b010, 3'b000, 15'h140, 16'd5, 16'd0, 3'b000, 3'b000, 3'b000, 0);
        tbl[10] = mk(1, 1, 0, 3'b010, 3'b010, 15'h140, 16'd5, 16'd1, 3'b000, 3'b000, 3'b000, 0);
        tbl[11] = mk(1, 1, 0, 3'b000, 3'b000, 15'h140, 16'd5, 16'd1, 3'b000, 3'b000, 3'b000, 0);
        tbl[12] = mk(1, 1, 0, 3'b010, 3'b000, 15'h140, 16'd5, 16'd1, 3'b000, 3'b000, 3'b000, 0);
        tbl[13] = mk(1, 1, 0, 3'b010, 3'b000, 15'h160, 16'd5, 16'd1, 3'b000, 3'b010, 3'b000, 0);
        tbl[14] = mk(1, 1, 0, 3'b010, 3'b010, 15'h160, 16'd5, 16'd2, 3'b000, 3'b010, 3'b000, 1);
        tbl[15] = mk(1, 1, 0, 3'b000, 3'b000, 15'h000, 16'd5, 16'd2, 3'b000, 3'b010, 3'b000, 1);
        tbl[16] = mk(1, 1, 0, 3'b100, 3'b000, 15'h000, 16'd5, 16'd2, 3'b000, 3'b010, 3'b000, 1);
        tbl[17] = mk(1, 1, 0, 3'b100, 3'b000, 15'h000, 16'd5, 16'd2, 3'b000, 3'b010, 3'b000, 1);
        tbl[18] = mk(1, 1, 0, 3'b000, 3'b000, 15'h000, 16'd5, 16'd2, 3'b100, 3'b010, 3'b000, 1);
        tbl[19] = mk(1, 1, 1, 3'b000, 3'b000, 15'h000, 16'd0, 16'd0, 3'b000, 3'b000, 3'b000, 0);
        tbl[20] = mk(1, 1, 0, 3'b000, 3'b000, 15'h000, 16'd0, 16'd0, 3'b000, 3'b000, 3'b000, 0);

        for (int i = 0; i < 21; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].rs, tbl[i].e, tbl[i].cl, tbl[i].vv, tbl[i].rr, tbl[i].dd);
            chk($sformatf("tbl%0d c0", i),   32'(xc_m[15:0]),  32'(tbl[i].c0));
            chk($sformatf("tbl%0d c1", i),   32'(xc_m[31:16]), 32'(tbl[i].c1));
            chk($sformatf("tbl%0d c2", i),   32'(xc_m[47:32]), 32'd0);
            chk($sformatf("tbl%0d drop", i), 32'(drop_m), 32'(tbl[i].dr));
            chk($sformatf("tbl%0d chg", i),  32'(chg_m),  32'(tbl[i].ch));
            chk($sformatf("tbl%0d tmo", i),  32'(tmo_m),  32'(tbl[i].tm));
            chk($sformatf("tbl%0d any", i),  32'(any_m),  32'(tbl[i].an));
        end

        // Timeout boundary on the small instance: flag after the 4th stalled edge, not the 3rd.
        for (int i = 1; i <= 3; i++) step("tmo_stall", 1, 1, 0, 3'b001, 3'b000, 15'h000);
        chk("tmo_after3", 32'(tmo_s[0]), 32'd0);
        step("tmo_stall4", 1, 1, 0, 3'b001, 3'b000, 15'h000);
        chk("tmo_after4", 32'(tmo_s[0]), 32'd1);
        chk("tmo_main_quiet", 32'(tmo_m[0]), 32'd0);
        step("tmo_drop", 1, 1, 0, 3'b000, 3'b000, 15'h000);
        step("tmo_clear", 1, 1, 1, 3'b000, 3'b000, 15'h000);

        // Counter saturation, then clear racing a transfer.
        for (int i = 0; i < 9; i++) step("sat_xfer", 1, 1, 0, 3'b001, 3'b001, 15'h000);
        chk("sat_small", 32'(xc_s[2:0]), 32'd7);
        chk("sat_main",  32'(xc_m[15:0]), 32'd9);
        step("sat_clear", 1, 1, 1, 3'b001, 3'b001, 15'h000);
        chk("clr_xfer_small", 32'(xc_s[2:0]), 32'd0);
        chk("clr_xfer_main",  32'(xc_m[15:0]), 32'd0);
        step("sat_idle", 1, 1, 0, 3'b000, 3'b000, 15'h000);

        // Reset in the middle of a stall: the stall restarts its age from 1 afterwards.
        step("rst_stall", 1, 1, 0, 3'b010, 3'b000, 15'h0A0);
        step("rst_stall", 1, 1, 0, 3'b010, 3'b000, 15'h0A0);
        step("rst_edge", 0, 1, 0, 3'b010, 3'b000, 15'h0A0);
        chk("rst_any", 32'(any_s), 32'd0);
        for (int i = 1; i <= 3; i++) step("rst_post", 1, 1, 0, 3'b010, 3'b000, 15'h0A0);
        chk("rst_tmo_after3", 32'(tmo_s[1]), 32'd0);
        chk("rst_flags_after3", 32'({drop_s, chg_s}), 32'd0);
        step("rst_post4", 1, 1, 0, 3'b010, 3'b000, 15'h0A0);
        chk("rst_tmo_after4", 32'(tmo_s[1]), 32'd1);
        step("rst_end", 1, 1, 1, 3'b000, 3'b000, 15'h0A0);

        // Randomized traffic; the second half starves ready so long stalls reach the main timeout.
        for (int n = 0; n < 500; n++) begin
            rstn = ($urandom_range(0, 149) != 0);
            en   = ($urandom_range(0, 24) != 0);
            clr  = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 5) != 0) v[c] = ($urandom_range(0, 3) != 0);
                if (n < 250) r[c] = $urandom_range(0, 1) != 0;
                else         r[c] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) d[c*DW +: DW] = DW'($urandom);
            end
            tick($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
